// File: rtl/framer_pkg.sv
// framer_pkg
//   Definitions shared by the patch stream framer and its consumers.
//   - framer_state_t : framer FSM encoding
//   - log2()         : ceiling log2 for sizing patch-number and pointer fields
//   - sof_num()      : patch number carried by an SOF meta record (N_PATCH-1)
//   - eof_num()      : patch number carried by an EOF meta record (N_PATCH-2)
//   A record is a meta record when patch_num[log2(N_PATCH)-1:1] is all ones.
//   Bit 0 then tells SOF (1) from EOF (0).
//   Data records use patch numbers 0..N_PATCH-3.
package framer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SOF_PEND = 2'd1,
      ST_STREAM   = 2'd2,
      ST_EOF_PEND = 2'd3
   } framer_state_t;

   function automatic int log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int sof_num(input int n_patch);
      return n_patch - 1;
   endfunction

   function automatic int eof_num(input int n_patch);
      return n_patch - 2;
   endfunction

endpackage

// File: rtl/framer_fifo.sv
// framer_fifo
//   Synchronous FIFO with a registered read port.
//   A push into a full FIFO is ignored; the caller detects that case with o_full.
//   A pop on an empty FIFO is ignored.
//   o_dout and o_dout_valid update one cycle after an accepted pop.
//   Ports:
//     CLK, RESET    clock, synchronous active-high reset (pointers, output register)
//     i_push/i_din  write request and data
//     i_pop         read request
//     o_full        no free entry
//     o_empty       no stored entry
//     o_dout        registered read data
//     o_dout_valid  o_dout carries a record popped on the previous cycle
module framer_fifo
   import framer_pkg::*;
#(
   parameter int WIDTH = 24,
   parameter int DEPTH = 8
)(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_dout_valid
);

   localparam int AW = log2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_dout;
   logic             r_dout_vld;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array without reset so it can map onto block RAM.
   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_din;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_dout     <= '0;
         r_dout_vld <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         r_dout_vld <= w_do_pop;
         if (w_do_pop) begin
            r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
      end
   end

   assign o_dout       = r_dout;
   assign o_dout_valid = r_dout_vld;

endmodule

// File: rtl/patch_stream_framer.sv
// patch_stream_framer
//   Per-camera front end of the sync/compander pipeline.
//   It numbers the incoming weighted sums of one camera as {patch_num, wtsum} records.
//   Each frame is bracketed with SOF (patch_num N_PATCH-1) and EOF (patch_num N_PATCH-2) meta records.
//   The wtsum field of a meta record is zero.
//   Ports:
//     CLK, RESET   clock, synchronous active-high reset
//     frame_start  pulse, a new camera frame begins
//     frame_end    pulse, the current frame is finished
//     in_valid     in_wtsum is valid this cycle
//     in_wtsum     patch weighted sum (FP_SIZE bits)
//     out_valid    out_data is valid; there is no backpressure
//     out_data     {patch_num, wtsum}
//     error        sticky error flag, cleared only by RESET
//     frame_cnt    (FRAMER_STATS_EN only) number of EOF records pushed
//     drop_cnt     (FRAMER_STATS_EN only) number of records dropped on error, saturating
//   Build option: define FRAMER_STATS_EN to add the frame_cnt/drop_cnt statistics ports.
//   Registers update without simulation delay.
module patch_stream_framer
   import framer_pkg::*;
#(
   parameter int FP_SIZE    = 20,
   parameter int N_PATCH    = 1024,
   parameter int FIFO_DEPTH = 8
)(
   input  logic                              CLK,
   input  logic                              RESET,
   input  logic                              frame_start,
   input  logic                              frame_end,
   input  logic                              in_valid,
   input  logic [FP_SIZE-1:0]                in_wtsum,
   output logic                              out_valid,
   output logic [log2(N_PATCH)+FP_SIZE-1:0]  out_data,
   output logic                              error
`ifdef FRAMER_STATS_EN
   ,
   output logic [31:0]                       frame_cnt,
   output logic [15:0]                       drop_cnt
`endif
);

   localparam int PN_W  = log2(N_PATCH);
   localparam int REC_W = PN_W + FP_SIZE;
   localparam logic [PN_W-1:0] SOF_PN  = PN_W'(sof_num(N_PATCH));
   localparam logic [PN_W-1:0] EOF_PN  = PN_W'(eof_num(N_PATCH));
   localparam logic [PN_W-1:0] CNT_ONE = PN_W'(1);

   framer_state_t     r_state;
   framer_state_t     w_state_next;
   logic [PN_W-1:0]   r_cnt;
   logic              r_hold_vld;
   logic [REC_W-1:0]  r_hold_data;
   logic              r_restart;
   logic              r_error;

   logic              w_accept;
   logic              w_overflow;
   logic              w_take;
   logic              w_meta_go;
   logic              w_hold_go;
   logic              w_take_direct;
   logic              w_take_hold;
   logic              w_hold_drop;
   logic              w_push;
   logic [REC_W-1:0]  w_push_data;
   logic              w_eof_push;
   logic              w_full_drop;
   logic              w_start_err;
   logic              w_fifo_full;
   logic              w_fifo_empty;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (frame_start) begin
               w_state_next = ST_SOF_PEND;
            end
         end
         // SOF always goes out on its first cycle, so an immediate frame_end just queues EOF behind it.
         ST_SOF_PEND: begin
            w_state_next = frame_end ? ST_EOF_PEND : ST_STREAM;
         end
         ST_STREAM: begin
            if (frame_start || frame_end) begin
               w_state_next = ST_EOF_PEND;
            end
         end
         // EOF waits while a held datum of the closing frame drains first.
         ST_EOF_PEND: begin
            if (!r_hold_vld) begin
               w_state_next = (r_restart || frame_start) ? ST_SOF_PEND : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM outputs: FIFO write-port arbitration ----------------
   always_comb begin
      w_accept      = 1'b0;
      w_overflow    = 1'b0;
      w_take        = 1'b0;
      w_meta_go     = 1'b0;
      w_hold_go     = 1'b0;
      w_take_direct = 1'b0;
      w_take_hold   = 1'b0;
      w_hold_drop   = 1'b0;
      w_push        = 1'b0;
      w_push_data   = '0;
      w_eof_push    = 1'b0;
      w_full_drop   = 1'b0;
      w_start_err   = 1'b0;

      // A datum belongs to a frame from the frame_start cycle itself up to the frame_end cycle.
      // Data in EOF_PEND, or in IDLE without frame_start, is dropped silently.
      w_accept   = in_valid && ((r_state == ST_STREAM) || (r_state == ST_SOF_PEND) ||
                                ((r_state == ST_IDLE) && frame_start));
      // Saturated counter: the next number would collide with EOF/SOF.
      w_overflow = w_accept && (r_cnt == EOF_PN);
      w_take     = w_accept && !w_overflow;

      // In SOF_PEND the hold register can only contain data of the new frame.
      // That data must follow SOF, so SOF wins there.
      // Everywhere else held data precedes meta.
      w_meta_go     = (r_state == ST_SOF_PEND) || ((r_state == ST_EOF_PEND) && !r_hold_vld);
      w_hold_go     = r_hold_vld && (r_state != ST_SOF_PEND);
      w_take_direct = w_take && (r_state == ST_STREAM) && !w_hold_go;
      w_take_hold   = w_take && !w_take_direct && (!r_hold_vld || w_hold_go);
      w_hold_drop   = w_take && !w_take_direct && !w_take_hold;

      w_push = w_meta_go || w_hold_go || w_take_direct;
      if (r_state == ST_SOF_PEND) begin
         w_push_data = {SOF_PN, {FP_SIZE{1'b0}}};
      end else if (w_hold_go) begin
         w_push_data = r_hold_data;
      end else if (w_meta_go) begin
         w_push_data = {EOF_PN, {FP_SIZE{1'b0}}};
      end else begin
         w_push_data = {r_cnt, in_wtsum};
      end

      w_eof_push  = (r_state == ST_EOF_PEND) && w_meta_go;
      w_full_drop = w_push && w_fifo_full;
      // frame_start together with frame_end is a clean back-to-back frame, not an error.
      w_start_err = (r_state == ST_STREAM) && frame_start && !frame_end;
   end

   // ---------------- counter, hold register, restart and error flags ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt       <= '0;
         r_hold_vld  <= 1'b0;
         r_hold_data <= '0;
         r_restart   <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         if (w_eof_push) begin
            r_cnt <= '0;
         end else if (w_take_direct || w_take_hold) begin
            r_cnt <= r_cnt + CNT_ONE;
         end

         if (w_take_hold) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= {r_cnt, in_wtsum};
         end else if (w_hold_go) begin
            r_hold_vld <= 1'b0;
         end

         // Remember a frame_start seen while the old frame is still closing.
         // After EOF the FSM then goes straight to SOF.
         if (r_state == ST_STREAM) begin
            r_restart <= frame_start;
         end else if (r_state == ST_EOF_PEND) begin
            r_restart <= r_hold_vld && (r_restart || frame_start);
         end else begin
            r_restart <= 1'b0;
         end

         if (w_overflow || w_hold_drop || w_full_drop || w_start_err) begin
            r_error <= 1'b1;
         end
      end
   end

   assign error = r_error;

   // ---------------- record FIFO; pops every cycle it holds data ----------------
   framer_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK          (CLK),
      .RESET        (RESET),
      .i_push       (w_push),
      .i_din        (w_push_data),
      .i_pop        (!w_fifo_empty),
      .o_full       (w_fifo_full),
      .o_empty      (w_fifo_empty),
      .o_dout       (out_data),
      .o_dout_valid (out_valid)
   );

`ifdef FRAMER_STATS_EN
   logic [31:0] r_frame_cnt;
   logic [15:0] r_drop_cnt;
   logic [1:0]  w_drop_n;
   logic [16:0] w_drop_sum;

   // At most two records can be lost in one cycle: a new datum plus the record pushed into a full FIFO.
   assign w_drop_n   = 2'(w_overflow) + 2'(w_hold_drop) + 2'(w_full_drop);
   assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_n);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_eof_push) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
         end
         r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
   end

   assign frame_cnt = r_frame_cnt;
   assign drop_cnt  = r_drop_cnt;
`endif

endmodule
